// File: rtl/digital_video.sv
// ============================================================================
// digital_video
// ----------------------------------------------------------------------------
// Purpose:
//   640x480@60 video timing generator with 3-bit digital RGB output. A free
//   running pixel counter publishes the current coordinate on xout/yout. The
//   upstream pixel source answers with 8-bit red/green/blue in the same cycle.
//   One register stage then quantises each channel to one bit and emits it
//   together with hsync/vsync/blank. All four outputs describe the same pixel.
//
// Configuration macro:
//   DIGITAL_VIDEO_DITHER_EN
//     Undefined (default): each channel is quantised to its MSB.
//     Defined: 4x4 ordered (Bayer) dither inside the active area.
//   Timing, latency and blanking are the same in both builds.
//
// Ports:
//   clk_25mhz  in   1   pixel clock, rising edge
//   rst        in   1   asynchronous reset, active low
//   red        in   8   red level for pixel (xout,yout)
//   green      in   8   green level for pixel (xout,yout)
//   blue       in   8   blue level for pixel (xout,yout)
//   xout       out  10  horizontal counter, 0..H_TOTAL-1
//   yout       out  10  vertical counter, 0..V_TOTAL-1
//   hsync_out  out  1   horizontal sync, aligned with rgbout
//   vsync_out  out  1   vertical sync, aligned with rgbout
//   blank_out  out  1   1 = outside the active area
//   rgbout     out  3   {R,G,B}, forced to 0 while blanked
// ============================================================================
module digital_video #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk_25mhz,
    input  logic       rst,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] xout,
    output logic [9:0] yout,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       blank_out,
    output logic [2:0] rgbout
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_blank;
    logic [2:0] r_rgb;

    logic       w_blank;
    logic       w_hsyncWin;
    logic       w_vsyncWin;
    logic [2:0] w_rgb;

    // Decode of the pixel currently on xout/yout. Sync windows are half-open
    // [START, END) so END is the first coordinate after the pulse.
    assign w_blank    = (r_x >= H_ACT_END) | (r_y >= V_ACT_END);
    assign w_hsyncWin = (r_x >= HS_START) & (r_x < HS_END);
    assign w_vsyncWin = (r_y >= VS_START) & (r_y < VS_END);

`ifdef DIGITAL_VIDEO_DITHER_EN
    logic [3:0] w_bayer;
    logic [7:0] w_thresh;

    // Bayer matrix M[y[1:0]][x[1:0]], indexed as {row, column}.
    always_comb begin
        w_bayer = 4'd0;
        case ({r_y[1:0], r_x[1:0]})
            4'b00_00: w_bayer = 4'd0;
            4'b00_01: w_bayer = 4'd8;
            4'b00_10: w_bayer = 4'd2;
            4'b00_11: w_bayer = 4'd10;
            4'b01_00: w_bayer = 4'd12;
            4'b01_01: w_bayer = 4'd4;
            4'b01_10: w_bayer = 4'd14;
            4'b01_11: w_bayer = 4'd6;
            4'b10_00: w_bayer = 4'd3;
            4'b10_01: w_bayer = 4'd11;
            4'b10_10: w_bayer = 4'd1;
            4'b10_11: w_bayer = 4'd9;
            4'b11_00: w_bayer = 4'd15;
            4'b11_01: w_bayer = 4'd7;
            4'b11_10: w_bayer = 4'd13;
            4'b11_11: w_bayer = 4'd5;
            default:  w_bayer = 4'd0;
        endcase
    end

    // 16*M + 8 is just M in the upper nibble with bit 3 set; max 248 fits.
    assign w_thresh = {w_bayer, 4'b1000};
    assign w_rgb    = {red > w_thresh, green > w_thresh, blue > w_thresh};
`else
    assign w_rgb    = {red[7], green[7], blue[7]};
`endif

    // Raster counters. xout/yout are these registers directly, so the
    // coordinate presented to the pixel source is never delayed.
    always_ff @(posedge clk_25mhz or negedge rst) begin
        if (!rst) begin
            r_x <= 10'd0;
            r_y <= 10'd0;
        end else if (r_x == H_LAST) begin
            r_x <= 10'd0;
            r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
            r_x <= r_x + 10'd1;
        end
    end

    // Single output stage: the edge that advances the counter also captures
    // the colour returned for the old coordinate, keeping rgb and the syncs
    // aligned on the same pixel.
    always_ff @(posedge clk_25mhz or negedge rst) begin
        if (!rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_blank <= 1'b1;
            r_rgb   <= 3'b000;
        end else begin
            r_hsync <= w_hsyncWin ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vsyncWin ? SYNC_POL : ~SYNC_POL;
            r_blank <= w_blank;
            r_rgb   <= w_blank ? 3'b000 : w_rgb;
        end
    end

    assign xout      = r_x;
    assign yout      = r_y;
    assign hsync_out = r_hsync;
    assign vsync_out = r_vsync;
    assign blank_out = r_blank;
    assign rgbout    = r_rgb;

endmodule

// File: tb/tb_digital_video.sv
// ============================================================================
// tb_digital_video
// ----------------------------------------------------------------------------
// Self-checking bench for digital_video. Horizontal timing is the real
// 640/16/96/48 line; the vertical geometry is shortened to 8 active lines,
// 2 front porch, 2 sync and 2 back porch so a whole frame (11200 cycles) fits
// comfortably in a short run. The reference model tracks the pixel index
// since reset and derives every expected output from the coordinate.
// Build with +define+DIGITAL_VIDEO_DITHER_EN to exercise the dither build.
// ============================================================================
module tb_digital_video;

    localparam int HA = 640;
    localparam int HFP = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VA = 8;
    localparam int VFP = 2;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam bit POL = 1'b0;
    localparam int NVEC = 8;

`ifdef DIGITAL_VIDEO_DITHER_EN
    localparam int BAYER [4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6},
                                    '{3, 11, 1, 9}, '{15, 7, 13, 5}};
`endif

    typedef struct {
        int         x;
        int         y;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] expRgb;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic [9:0] xout;
    logic [9:0] yout;
    logic       hsync_out;
    logic       vsync_out;
    logic       blank_out;
    logic [2:0] rgbout;

    int compared = 0;
    int mismatched = 0;
    int pixIdx = 0;
    int lastX = 0;
    int lastY = 0;
    vec_t vecs [NVEC];

    digital_video #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk_25mhz(clk),
        .rst(rst),
        .red(red),
        .green(green),
        .blue(blue),
        .xout(xout),
        .yout(yout),
        .hsync_out(hsync_out),
        .vsync_out(vsync_out),
        .blank_out(blank_out),
        .rgbout(rgbout)
    );

    // 25 MHz pixel clock
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Expected {hsync, vsync, blank, rgb} for pixel (x,y) with given colours
    function automatic logic [5:0] refOut(input int x, input int y,
                                          input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        logic       bl;
        logic       hsv;
        logic       vsv;
        logic [2:0] c;
        bl  = (x >= HA) || (y >= VA);
        hsv = (x >= HA + HFP && x < HA + HFP + HS) ? POL : !POL;
        vsv = (y >= VA + VFP && y < VA + VFP + VS) ? POL : !POL;
`ifdef DIGITAL_VIDEO_DITHER_EN
        begin
            int t;
            t = 16 * BAYER[y % 4][x % 4] + 8;
            c = {int'(r) > t, int'(g) > t, int'(b) > t};
        end
`else
        c = {r >= 8'd128, g >= 8'd128, b >= 8'd128};
`endif
        if (bl) c = 3'b000;
        return {hsv, vsv, bl, c};
    endfunction

    // Compare one value and log a failure
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            if (mismatched <= 30)
                $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Drive one pixel's colours, clock once, check against the model
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g,
                                 input logic [7:0] b);
        int x;
        int y;
        logic [5:0] e;
        x = pixIdx % HT;
        y = pixIdx / HT;
        red = r;
        green = g;
        blue = b;
        @(posedge clk);
        #1;
        lastX = x;
        lastY = y;
        pixIdx = (pixIdx + 1) % FRAME;
        e = refOut(x, y, r, g, b);
        checkOutput("pixel", {6'd0, xout, yout, hsync_out, vsync_out, blank_out, rgbout},
                    {6'd0, 10'(pixIdx % HT), 10'(pixIdx / HT), e});
    endtask

    task automatic randomStep();
        applyStimulus(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    // Step with random colours until (x,y) is the coordinate on xout/yout
    task automatic advanceTo(input int x, input int y);
        int guard;
        guard = 0;
        while (pixIdx != y * HT + x && guard < FRAME) begin
            randomStep();
            guard++;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, 32'(xout), 32'd0);
        checkOutput({tag, "_y"}, 32'(yout), 32'd0);
        checkOutput({tag, "_rgb"}, 32'(rgbout), 32'd0);
        checkOutput({tag, "_blank"}, 32'(blank_out), 32'd1);
        checkOutput({tag, "_hsync"}, 32'(hsync_out), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(vsync_out), 32'd1);
    endtask

    initial begin
        int cnt;
        int cnt2;
        int wraps;
        int prevY;
        int startIdx;

`ifdef DIGITAL_VIDEO_DITHER_EN
        vecs[0] = '{0, 0, 8'd80,  8'd80,  8'd80,  3'b111};
        vecs[1] = '{1, 0, 8'd80,  8'd80,  8'd80,  3'b000};
        vecs[2] = '{3, 0, 8'd200, 8'd200, 8'd200, 3'b111};
        vecs[3] = '{2, 1, 8'd200, 8'd200, 8'd200, 3'b000};
        vecs[4] = '{0, 3, 8'd249, 8'd249, 8'd249, 3'b111};
        vecs[5] = '{3, 3, 8'd255, 8'd255, 8'd255, 3'b111};
        vecs[6] = '{4, 4, 8'd0,   8'd0,   8'd0,   3'b000};
        vecs[7] = '{0, 7, 8'd248, 8'd248, 8'd248, 3'b000};
`else
        vecs[0] = '{0,   0,  8'd80,  8'd80,  8'd80,  3'b000};
        vecs[1] = '{1,   0,  8'd200, 8'd80,  8'd80,  3'b100};
        vecs[2] = '{639, 0,  8'd128, 8'd127, 8'd255, 3'b101};
        vecs[3] = '{640, 0,  8'd255, 8'd255, 8'd255, 3'b000};
        vecs[4] = '{0,   1,  8'd127, 8'd128, 8'd0,   3'b010};
        vecs[5] = '{700, 1,  8'd255, 8'd255, 8'd255, 3'b000};
        vecs[6] = '{5,   VA - 1, 8'd255, 8'd255, 8'd255, 3'b111};
        vecs[7] = '{5,   VA, 8'd255, 8'd255, 8'd255, 3'b000};
`endif

        // Reset held while the clock runs
        rst = 1'b0;
        red = 8'd0;
        green = 8'd0;
        blue = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");

        // One line after release
        rst = 1'b1;
        pixIdx = 0;
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < HT; i++) begin
            randomStep();
            if (blank_out == 1'b0) cnt++;
            if (hsync_out == 1'b0) cnt2++;
            if (i == 0) checkOutput("first_x", 32'(xout), 32'd1);
        end
        checkOutput("line_active_count", 32'(cnt), 32'(HA));
        checkOutput("line_hsync_count", 32'(cnt2), 32'(HS));
        checkOutput("line_end_x", 32'(xout), 32'd0);
        checkOutput("line_end_y", 32'(yout), 32'd1);

        // One full frame
        startIdx = pixIdx;
        cnt = 0;
        wraps = 0;
        for (int i = 0; i < FRAME; i++) begin
            prevY = int'(yout);
            randomStep();
            if (vsync_out == 1'b0) cnt++;
            if (prevY == VT - 1 && yout == 10'd0) wraps++;
        end
        checkOutput("frame_vsync_count", 32'(cnt), 32'(VS * HT));
        checkOutput("frame_y_wraps", 32'(wraps), 32'd1);
        checkOutput("frame_period", 32'({xout, yout}),
                    32'({10'(startIdx % HT), 10'(startIdx / HT)}));

`ifndef DIGITAL_VIDEO_DITHER_EN
        // Flat grey below threshold, then bright red, over whole lines
        advanceTo(0, 2);
        cnt = 0;
        for (int i = 0; i < HT; i++) begin
            applyStimulus(8'd80, 8'd80, 8'd80);
            if (rgbout != 3'b000) cnt++;
        end
        checkOutput("grey80_nonzero", 32'(cnt), 32'd0);
        cnt = 0;
        cnt2 = 0;
        for (int i = 0; i < HT; i++) begin
            applyStimulus(8'd200, 8'd80, 8'd80);
            if (lastX < HA && lastY < VA && rgbout == 3'b100) cnt++;
            if (lastX >= HA && rgbout != 3'b000) cnt2++;
        end
        checkOutput("red200_active", 32'(cnt), 32'(HA));
        checkOutput("red200_blank", 32'(cnt2), 32'd0);
`endif

        // Table of specific pixels, in raster order
        for (int v = 0; v < NVEC; v++) begin
            advanceTo(vecs[v].x, vecs[v].y);
            applyStimulus(vecs[v].r, vecs[v].g, vecs[v].b);
            checkOutput($sformatf("vec%0d_rgb", v), 32'(rgbout), 32'(vecs[v].expRgb));
        end

`ifdef DIGITAL_VIDEO_DITHER_EN
        // One 4x4 tile of level 80: five cells have M <= 4
        advanceTo(0, 0);
        cnt = 0;
        for (int i = 0; i < 4 * HT; i++) begin
            applyStimulus(8'd80, 8'd80, 8'd80);
            if (lastX < 4 && rgbout == 3'b111) cnt++;
        end
        checkOutput("tile80_lit", 32'(cnt), 32'd5);
`endif

        // Asynchronous reset mid-frame
        advanceTo(300, 5);
        #5;
        rst = 1'b0;
        #1;
        checkResetValues("async");
        @(posedge clk);
        #1;
        checkOutput("held_x", 32'(xout), 32'd0);
        rst = 1'b1;
        pixIdx = 0;
        for (int i = 0; i < 20; i++) randomStep();
        checkOutput("restart_x", 32'(xout), 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
